// File: rtl/dma_burst_scheduler_if.sv
// Grant bus between the per-channel request logic and the burst scheduler.
// DMA_SCHED_TIMEOUT_EN adds the timeout_err stall-abort pulse.
interface dma_burst_scheduler_if #(
   parameter int NUM_CHAN = 4
);
   localparam int IDW = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;

   logic [NUM_CHAN-1:0] req;
   logic                beat_done;
   logic [NUM_CHAN-1:0] grant;
   logic                grant_valid;
   logic [IDW-1:0]      grant_id;
   logic                burst_end;
`ifdef DMA_SCHED_TIMEOUT_EN
   logic                timeout_err;

   modport master (
      input  req, beat_done,
      output grant, grant_valid, grant_id, burst_end, timeout_err
   );
   modport slave (
      output req, beat_done,
      input  grant, grant_valid, grant_id, burst_end, timeout_err
   );
`else
   modport master (
      input  req, beat_done,
      output grant, grant_valid, grant_id, burst_end
   );
   modport slave (
      output req, beat_done,
      input  grant, grant_valid, grant_id, burst_end
   );
`endif
endinterface

// File: rtl/dma_burst_scheduler.sv
// Burst-locked round-robin scheduler for the shared AHB master datapath.
// Optional stall abort enabled by defining DMA_SCHED_TIMEOUT_EN.
module dma_burst_scheduler #(
   parameter int NUM_CHAN  = 4,
   parameter int BURST_LEN = 4,
   parameter int TIMEOUT   = 64
) (
   input logic                  clk,
   input logic                  rst_n,
   dma_burst_scheduler_if.master bus
);
   localparam int IDW = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;
   localparam int CW  = (BURST_LEN > 1) ? $clog2(BURST_LEN + 1) : 1;

   if (NUM_CHAN < 2 || BURST_LEN < 1 || TIMEOUT < 2) begin : g_param_check
      $error("dma_burst_scheduler: illegal parameter set");
   end

   typedef enum logic {ST_IDLE, ST_BURST} state_t;

   state_t              state_q;
   logic [IDW-1:0]      last_q;
   logic [CW-1:0]       beat_cnt_q;
   logic [NUM_CHAN-1:0] grant_q;
   logic                grant_valid_q;
   logic [IDW-1:0]      grant_id_q;
   logic                burst_end_q;

   logic                pick_found_d;
   logic [IDW-1:0]      pick_idx_d;
   logic [NUM_CHAN-1:0] pick_grant_d;
   logic                last_beat_d;
   logic                full_done_d;
   logic                early_rel_d;
   logic                timeout_d;
   logic                release_d;

`ifdef DMA_SCHED_TIMEOUT_EN
   localparam int SW = $clog2(TIMEOUT);
   logic [SW-1:0]       stall_q;
   logic                timeout_err_q;
`endif

   // Descending scan so the nearest channel after last_q is the final writer.
   always_comb begin
      logic [IDW-1:0] cand;
      cand         = '0;
      pick_found_d = 1'b0;
      pick_idx_d   = '0;
      for (int i = NUM_CHAN; i >= 1; i--) begin
         cand = IDW'((int'(last_q) + i) % NUM_CHAN);
         if (bus.req[cand]) begin
            pick_found_d = 1'b1;
            pick_idx_d   = cand;
         end
      end
      pick_grant_d             = '0;
      pick_grant_d[pick_idx_d] = pick_found_d;
   end

   always_comb begin
      last_beat_d = (beat_cnt_q == CW'(BURST_LEN - 1));
      full_done_d = (state_q == ST_BURST) && bus.beat_done && last_beat_d;
      early_rel_d = (state_q == ST_BURST) && !full_done_d && !bus.req[grant_id_q];
`ifdef DMA_SCHED_TIMEOUT_EN
      timeout_d   = (state_q == ST_BURST) && !full_done_d && !early_rel_d &&
                    !bus.beat_done && (stall_q == SW'(TIMEOUT - 1));
`else
      timeout_d   = 1'b0;
`endif
      release_d   = full_done_d || early_rel_d || timeout_d;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         last_q        <= IDW'(NUM_CHAN - 1);
         beat_cnt_q    <= '0;
         grant_q       <= '0;
         grant_valid_q <= 1'b0;
         grant_id_q    <= '0;
         burst_end_q   <= 1'b0;
`ifdef DMA_SCHED_TIMEOUT_EN
         stall_q       <= '0;
         timeout_err_q <= 1'b0;
`endif
      end else begin
         burst_end_q <= 1'b0;
`ifdef DMA_SCHED_TIMEOUT_EN
         timeout_err_q <= 1'b0;
`endif
         case (state_q)
            ST_IDLE: begin
               if (pick_found_d) begin
                  state_q       <= ST_BURST;
                  last_q        <= pick_idx_d;
                  beat_cnt_q    <= '0;
                  grant_q       <= pick_grant_d;
                  grant_valid_q <= 1'b1;
                  grant_id_q    <= pick_idx_d;
`ifdef DMA_SCHED_TIMEOUT_EN
                  stall_q       <= '0;
`endif
               end
            end
            ST_BURST: begin
               if (release_d) begin
                  state_q       <= ST_IDLE;
                  grant_q       <= '0;
                  grant_valid_q <= 1'b0;
                  grant_id_q    <= '0;
                  burst_end_q   <= full_done_d;
`ifdef DMA_SCHED_TIMEOUT_EN
                  timeout_err_q <= timeout_d;
`endif
               end
               // An early-release beat is still counted; the counter is reloaded on the next grant anyway.
               if (full_done_d) begin
                  beat_cnt_q <= '0;
               end else if (bus.beat_done) begin
                  beat_cnt_q <= beat_cnt_q + CW'(1);
               end
`ifdef DMA_SCHED_TIMEOUT_EN
               if (bus.beat_done || release_d) begin
                  stall_q <= '0;
               end else begin
                  stall_q <= stall_q + SW'(1);
               end
`endif
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.grant       = grant_q;
   assign bus.grant_valid = grant_valid_q;
   assign bus.grant_id    = grant_id_q;
   assign bus.burst_end   = burst_end_q;
`ifdef DMA_SCHED_TIMEOUT_EN
   assign bus.timeout_err = timeout_err_q;
`endif

endmodule

// File: tb/tb_dma_burst_scheduler.sv
// Directed bench for dma_burst_scheduler (4 channels, 4-beat bursts, TIMEOUT=8).
module tb_dma_burst_scheduler;
   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_err;

   dma_burst_scheduler_if #(.NUM_CHAN(4)) bus_if ();

   dma_burst_scheduler #(
      .NUM_CHAN  (4),
      .BURST_LEN (4),
      .TIMEOUT   (8)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Inputs change and outputs are observed 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic exp_out(input string tag, input logic [3:0] g, input int id, input logic be);
      check({tag, ".grant"}, 32'(bus_if.grant), 32'(g));
      check({tag, ".gvalid"}, 32'(bus_if.grant_valid), 32'(|g));
      check({tag, ".gid"}, 32'(bus_if.grant_id), 32'(id));
      check({tag, ".bend"}, 32'(bus_if.burst_end), 32'(be));
      $display("  %-10s grant=%b id=%0d burst_end=%b", tag, bus_if.grant, bus_if.grant_id, bus_if.burst_end);
   endtask

   initial begin
      logic [3:0] exp_g;
      n_cmp = 0;
      n_err = 0;
      rst_n = 1'b0;
      bus_if.req = 4'b1111;
      bus_if.beat_done = 1'b0;

      // Reset held with all requests
      repeat (3) step();
      exp_out("rst", 4'b0000, 0, 1'b0);
      rst_n = 1'b1;
      step();
      exp_out("rst_rel", 4'b0001, 0, 1'b0);

      // Full rotation with beat_done always high
      bus_if.beat_done = 1'b1;
      for (int k = 0; k < 5; k++) begin
         exp_g = 4'b0001 << (k % 4);
         for (int c = 0; c < 4; c++) begin
            exp_out($sformatf("rot%0d_b%0d", k, c), exp_g, k % 4, 1'b0);
            step();
         end
         exp_out($sformatf("rot%0d_end", k), 4'b0000, 0, 1'b1);
         step();
      end
      exp_out("rot_next", 4'b0010, 1, 1'b0);

      // Reset mid-burst
      rst_n = 1'b0;
      bus_if.req = 4'b0000;
      bus_if.beat_done = 1'b0;
      step();
      exp_out("rst_mid", 4'b0000, 0, 1'b0);
      rst_n = 1'b1;

      // Single requester, back-to-back bursts
      bus_if.req = 4'b0001;
      step();
      exp_out("one_g", 4'b0001, 0, 1'b0);
      bus_if.beat_done = 1'b1;
      for (int c = 1; c < 4; c++) begin
         step();
         exp_out($sformatf("one_b%0d", c), 4'b0001, 0, 1'b0);
      end
      step();
      exp_out("one_end", 4'b0000, 0, 1'b1);
      step();
      exp_out("one_regnt", 4'b0001, 0, 1'b0);
      bus_if.beat_done = 1'b0;
      bus_if.req = 4'b0000;
      step();
      exp_out("one_drop", 4'b0000, 0, 1'b0);

      // Early release of ch1 after two beats, then ch3
      bus_if.req = 4'b1010;
      step();
      exp_out("er_g", 4'b0010, 1, 1'b0);
      bus_if.beat_done = 1'b1;
      step();
      exp_out("er_b1", 4'b0010, 1, 1'b0);
      step();
      exp_out("er_b2", 4'b0010, 1, 1'b0);
      bus_if.req = 4'b1000;
      bus_if.beat_done = 1'b0;
      step();
      exp_out("er_rel", 4'b0000, 0, 1'b0);
      step();
      exp_out("er_ch3", 4'b1000, 3, 1'b0);
      bus_if.req = 4'b0000;
      step();
      exp_out("er_ch3rel", 4'b0000, 0, 1'b0);

      // Beats while idle are ignored; ch2 still needs four fresh beats
      bus_if.beat_done = 1'b1;
      repeat (3) step();
      exp_out("idle_bd", 4'b0000, 0, 1'b0);
      bus_if.req = 4'b0100;
      step();
      exp_out("ib_g", 4'b0100, 2, 1'b0);
      repeat (3) step();
      exp_out("ib_b3", 4'b0100, 2, 1'b0);
      step();
      exp_out("ib_end", 4'b0000, 0, 1'b1);

      // Reset mid-burst of ch2, pointer returns to NUM_CHAN-1
      bus_if.beat_done = 1'b0;
      step();
      exp_out("rm_g", 4'b0100, 2, 1'b0);
      step();
      rst_n = 1'b0;
      step();
      exp_out("rm_rst", 4'b0000, 0, 1'b0);
      rst_n = 1'b1;
      bus_if.req = 4'b1111;
      step();
      exp_out("rm_regnt", 4'b0001, 0, 1'b0);

      // Last beat coincident with req drop: completion wins
      bus_if.beat_done = 1'b1;
      repeat (3) step();
      exp_out("pri_b3", 4'b0001, 0, 1'b0);
      bus_if.req = 4'b0000;
      step();
      exp_out("pri_end", 4'b0000, 0, 1'b1);
      bus_if.beat_done = 1'b0;
      step();
      exp_out("pri_idle", 4'b0000, 0, 1'b0);

`ifdef DMA_SCHED_TIMEOUT_EN
      // Stall abort after 8 cycles without beat_done
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      bus_if.req = 4'b0011;
      step();
      exp_out("to_g", 4'b0001, 0, 1'b0);
      for (int c = 1; c < 8; c++) begin
         step();
         check($sformatf("to_s%0d.terr", c), 32'(bus_if.timeout_err), 32'd0);
         check($sformatf("to_s%0d.grant", c), 32'(bus_if.grant), 32'(4'b0001));
      end
      step();
      check("to_abort.terr", 32'(bus_if.timeout_err), 32'd1);
      exp_out("to_abort", 4'b0000, 0, 1'b0);
      step();
      check("to_next.terr", 32'(bus_if.timeout_err), 32'd0);
      exp_out("to_next", 4'b0010, 1, 1'b0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
